// File: rtl/aes_pkg.sv
// AES-wide op encodings shared by the cipher datapath and its S-boxes.
package aes_pkg;

   localparam int unsigned OpWidth = 2;

   typedef enum logic [OpWidth-1:0] {
      OpFwd = 2'b01,
      OpInv = 2'b10
   } aes_op_e;

endpackage

// File: rtl/aes_sbox_canright_pkg.sv
// Canright tower-field helpers: basis-change matrices and GF(2^2)/GF(2^4)/GF(2^8) arithmetic.
// Field elements use normal bases: [Omega^2, Omega] for GF(2^2), [alpha^8, alpha^2] for GF(2^4).
package aes_sbox_canright_pkg;

   localparam logic [7:0] AffineConst = 8'h63;

   // Row k of each matrix is the image of input bit k (row 0 listed last).
   localparam logic [7:0][7:0] A2X = {8'h98, 8'hf3, 8'hf2, 8'h48, 8'h09, 8'h81, 8'ha9, 8'hff};
   localparam logic [7:0][7:0] X2A = {8'h64, 8'h78, 8'h6e, 8'h8c, 8'h68, 8'h29, 8'hde, 8'h60};
   localparam logic [7:0][7:0] X2S = {8'h58, 8'h2d, 8'h9e, 8'h0b, 8'hdc, 8'h04, 8'h03, 8'h24};
   localparam logic [7:0][7:0] S2X = {8'h8c, 8'h79, 8'h05, 8'heb, 8'h12, 8'h04, 8'h51, 8'h53};

   // Bit-matrix times vector over GF(2).
   function automatic logic [7:0] aes_mvm(input logic [7:0] vec, input logic [7:0][7:0] mat);
      logic [7:0] res;
      res = '0;
      for (int k = 0; k < 8; k++) begin
         if (vec[k]) res = res ^ mat[k];
      end
      return res;
   endfunction

   function automatic logic [1:0] aes_mul_gf2p2(input logic [1:0] g, input logic [1:0] d);
      logic a, b, c;
      a = g[1] & d[1];
      b = (^g) & (^d);
      c = g[0] & d[0];
      return {a ^ b, c ^ b};
   endfunction

   function automatic logic [1:0] aes_scale_omega2_gf2p2(input logic [1:0] g);
      return {g[0], g[1] ^ g[0]};
   endfunction

   function automatic logic [1:0] aes_scale_omega_gf2p2(input logic [1:0] g);
      return {g[1] ^ g[0], g[1]};
   endfunction

   // Squaring in a normal basis is a swap of the coordinates.
   function automatic logic [1:0] aes_square_gf2p2(input logic [1:0] g);
      return {g[0], g[1]};
   endfunction

   function automatic logic [3:0] aes_mul_gf2p4(input logic [3:0] g, input logic [3:0] d);
      logic [1:0] a, b, c;
      a = aes_mul_gf2p2(g[3:2], d[3:2]);
      b = aes_mul_gf2p2(g[3:2] ^ g[1:0], d[3:2] ^ d[1:0]);
      c = aes_mul_gf2p2(g[1:0], d[1:0]);
      return {a ^ aes_scale_omega2_gf2p2(b), c ^ aes_scale_omega2_gf2p2(b)};
   endfunction

   // Square then scale by nu in GF(2^4)/GF(2^2).
   function automatic logic [3:0] aes_square_scale_gf2p4(input logic [3:0] g);
      logic [1:0] a, b;
      a = g[3:2] ^ g[1:0];
      b = aes_square_gf2p2(g[1:0]);
      return {aes_square_gf2p2(a), aes_scale_omega_gf2p2(b)};
   endfunction

   function automatic logic [3:0] aes_inverse_gf2p4(input logic [3:0] g);
      logic [1:0] a, b, c, d;
      a = g[3:2] ^ g[1:0];
      b = aes_mul_gf2p2(g[3:2], g[1:0]);
      c = aes_scale_omega2_gf2p2(aes_square_gf2p2(a));
      d = aes_square_gf2p2(c ^ b);
      return {aes_mul_gf2p2(d, g[1:0]), aes_mul_gf2p2(d, g[3:2])};
   endfunction

   // First half of the GF(2^8) inverse: the GF(2^4) element that must be inverted.
   function automatic logic [3:0] aes_inv_gf2p8_pre(input logic [7:0] g);
      logic [3:0] b, c;
      b = aes_mul_gf2p4(g[7:4], g[3:0]);
      c = aes_square_scale_gf2p4(g[7:4] ^ g[3:0]);
      return c ^ b;
   endfunction

   // Second half of the GF(2^8) inverse, given the GF(2^4) inverse d.
   function automatic logic [7:0] aes_inv_gf2p8_post(input logic [7:0] g, input logic [3:0] d);
      return {aes_mul_gf2p4(d, g[3:0]), aes_mul_gf2p4(d, g[7:4])};
   endfunction

   function automatic logic [7:0] aes_inverse_gf2p8(input logic [7:0] g);
      return aes_inv_gf2p8_post(g, aes_inverse_gf2p4(aes_inv_gf2p8_pre(g)));
   endfunction

   // Map an input byte into the normal basis X (undoing the affine step when inverting).
   function automatic logic [7:0] aes_to_x(input logic [7:0] d, input logic inv);
      return inv ? aes_mvm(d ^ AffineConst, S2X) : aes_mvm(d, A2X);
   endfunction

   // Map an inverted element back out of basis X (applying the affine step when forward).
   function automatic logic [7:0] aes_from_x(input logic [7:0] y, input logic inv);
      return inv ? aes_mvm(y, X2A) : (aes_mvm(y, X2S) ^ AffineConst);
   endfunction

endpackage

// File: rtl/aes_sbox_canright_pipe_stage.sv
// Elastic register slice: one valid/data register with a combinational ready path and flush.
module aes_sbox_canright_pipe_stage #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [Width-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Width-1:0] out_data_o
);

   logic             valid_d, valid_q;
   logic [Width-1:0] data_d, data_q;

   // Load when empty or draining this cycle; flush freezes the handshake and drops content.
   always_comb begin
      in_ready_o = (!valid_q || out_ready_i) && !flush_i;
      valid_d    = valid_q;
      data_d     = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (in_ready_o) begin
         valid_d = in_valid_i;
         if (in_valid_i) data_d = in_data_i;
      end
   end

   // Slot state with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

endmodule

// File: rtl/aes_sbox_canright_pipe.sv
// Multi-lane pipelined Canright AES S-box (forward/inverse) with valid/ready, flush and op error.
module aes_sbox_canright_pipe
   import aes_pkg::*;
   import aes_sbox_canright_pkg::*;
#(
   parameter int unsigned NumLanes = 4,
   parameter int unsigned PipeRegs = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [OpWidth-1:0]    op_i,
   input  logic [8*NumLanes-1:0] data_i,
   input  logic                  flush_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [8*NumLanes-1:0] data_o,
   output logic                  op_err_o
);

   if (PipeRegs == 1) begin : g_one
      logic [8*NumLanes-1:0] res;
      logic                  op_err_d;

      // Full per-lane substitution ahead of the single output register.
      always_comb begin
         res = '0;
         for (int k = 0; k < NumLanes; k++) begin
            res[8*k +: 8] = aes_from_x(aes_inverse_gf2p8(aes_to_x(data_i[8*k +: 8], op_i == OpInv)),
                                       op_i == OpInv);
         end
      end

      // Illegal ops are computed as forward and flagged.
      assign op_err_d = (op_i != OpFwd) && (op_i != OpInv);

      aes_sbox_canright_pipe_stage #(
         .Width(8*NumLanes + 1)
      ) u_stage_out (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .flush_i    (flush_i),
         .in_valid_i (in_valid_i),
         .in_ready_o (in_ready_o),
         .in_data_i  ({op_err_d, res}),
         .out_valid_o(out_valid_o),
         .out_ready_i(out_ready_i),
         .out_data_o ({op_err_o, data_o})
      );
   end else begin : g_two
      logic [8*NumLanes-1:0] gamma_d, gamma_q, res;
      logic [4*NumLanes-1:0] ginv_d, ginv_q;
      logic [OpWidth-1:0]    op_q;
      logic                  mid_valid, out_stage_ready, op_err_d;

      // Front half: basis change and the GF(2^4) inverse input, per lane.
      always_comb begin
         gamma_d = '0;
         ginv_d  = '0;
         for (int k = 0; k < NumLanes; k++) begin
            gamma_d[8*k +: 8] = aes_to_x(data_i[8*k +: 8], op_i == OpInv);
            ginv_d[4*k +: 4]  = aes_inv_gf2p8_pre(aes_to_x(data_i[8*k +: 8], op_i == OpInv));
         end
      end

      // The op is shared by all lanes, so one copy travels with the transaction.
      aes_sbox_canright_pipe_stage #(
         .Width(12*NumLanes + OpWidth)
      ) u_stage_mid (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .flush_i    (flush_i),
         .in_valid_i (in_valid_i),
         .in_ready_o (in_ready_o),
         .in_data_i  ({op_i, ginv_d, gamma_d}),
         .out_valid_o(mid_valid),
         .out_ready_i(out_stage_ready),
         .out_data_o ({op_q, ginv_q, gamma_q})
      );

      // Back half: GF(2^4) inverse, recombination and output basis change, per lane.
      always_comb begin
         res = '0;
         for (int k = 0; k < NumLanes; k++) begin
            res[8*k +: 8] = aes_from_x(aes_inv_gf2p8_post(gamma_q[8*k +: 8],
                                                          aes_inverse_gf2p4(ginv_q[4*k +: 4])),
                                       op_q == OpInv);
         end
      end

      assign op_err_d = (op_q != OpFwd) && (op_q != OpInv);

      aes_sbox_canright_pipe_stage #(
         .Width(8*NumLanes + 1)
      ) u_stage_out (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .flush_i    (flush_i),
         .in_valid_i (mid_valid),
         .in_ready_o (out_stage_ready),
         .in_data_i  ({op_err_d, res}),
         .out_valid_o(out_valid_o),
         .out_ready_i(out_ready_i),
         .out_data_o ({op_err_o, data_o})
      );
   end

endmodule

// File: tb/tb_aes_sbox_canright_pipe.sv
// Bench for aes_sbox_canright_pipe: directed steps plus random traffic against a GF(2^8) model.
module tb_aes_sbox_canright_pipe;

   localparam int unsigned NumLanes = 4;
   localparam int unsigned PipeRegs = 2;
   localparam int unsigned W        = 8 * NumLanes;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT (4 lanes, 2 registers)
   logic         rst_n, in_valid, in_ready, flush, out_valid, out_ready, op_err;
   logic [1:0]   op;
   logic [W-1:0] data_in, data_out;

   // Small DUT (1 lane, 1 register)
   logic       b_rst_n, b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_op_err;
   logic [1:0] b_op;
   logic [7:0] b_data_in, b_data_out;

   aes_sbox_canright_pipe #(
      .NumLanes(NumLanes),
      .PipeRegs(PipeRegs)
   ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .op_i       (op),
      .data_i     (data_in),
      .flush_i    (flush),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .data_o     (data_out),
      .op_err_o   (op_err)
   );

   aes_sbox_canright_pipe #(
      .NumLanes(1),
      .PipeRegs(1)
   ) u_dut_small (
      .clk_i      (clk),
      .rst_ni     (b_rst_n),
      .in_valid_i (b_in_valid),
      .in_ready_o (b_in_ready),
      .op_i       (b_op),
      .data_i     (b_data_in),
      .flush_i    (b_flush),
      .out_valid_o(b_out_valid),
      .out_ready_i(b_out_ready),
      .data_o     (b_data_out),
      .op_err_o   (b_op_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] fwd_tab [256];
   logic [7:0] inv_tab [256];
   logic [W:0] exp_q[$];
   logic       hold_armed;
   logic [W:0] held;
   int         in_fire;

   // Polynomial-basis GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] x);
      for (int y = 1; y < 256; y++) begin
         if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
      end
      return 8'h00;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [W:0] expect_word(input logic [1:0] o, input logic [W-1:0] d);
      logic [W:0] r;
      r[W] = (o != 2'b01) && (o != 2'b10);
      for (int k = 0; k < NumLanes; k++) begin
         r[8*k +: 8] = (o == 2'b10) ? inv_tab[d[8*k +: 8]] : fwd_tab[d[8*k +: 8]];
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock of the main DUT: sample just before the edge, update the scoreboard, step.
   task automatic tick();
      logic [W:0] got;
      #1;
      got     = {op_err, data_out};
      in_fire = 0;
      if (hold_armed) begin
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_hold", 64'(got), 64'(held));
      end
      hold_armed = rst_n && !flush && out_valid && !out_ready;
      held       = got;
      if (!rst_n) begin
         exp_q.delete();
      end else if (flush) begin
         check("flush_ready", 64'(in_ready), 64'd0);
         exp_q.delete();
      end else begin
         if (exp_q.size() == 0) check("idle_valid", 64'(out_valid), 64'd0);
         check("ready", 64'(in_ready), 64'((exp_q.size() < PipeRegs) || out_ready));
         if (out_valid && out_ready && exp_q.size() != 0) begin
            check("data", 64'(got), 64'(exp_q.pop_front()));
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(expect_word(op, data_in));
            in_fire = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] s;
      int sent;

      for (int b = 0; b < 256; b++) begin
         s = ginv(8'(b));
         fwd_tab[b] = s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
      end
      for (int b = 0; b < 256; b++) inv_tab[fwd_tab[b]] = 8'(b);

      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; op = 2'b01; data_in = '0;
      b_rst_n = 1'b0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1; b_op = 2'b01;
      b_data_in = 8'h00;
      hold_armed = 1'b0; held = '0;

      // Reset state
      tick(); tick();
      rst_n = 1'b1; b_rst_n = 1'b1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data", 64'(data_out), 64'd0);
      check("rst_err", 64'(op_err), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd1);

      // Forward known bytes, latency 2
      in_valid = 1'b1; op = 2'b01; data_in = 32'h530100FF;
      tick();
      in_valid = 1'b0;
      check("t1_lat1", 64'(out_valid), 64'd0);
      tick();
      check("t1_lat2", 64'(out_valid), 64'd1);
      check("t1_data", 64'(data_out), 64'hED7C6316);
      check("t1_err", 64'(op_err), 64'd0);
      tick();

      // Inverse known bytes
      in_valid = 1'b1; op = 2'b10; data_in = 32'h16637CED;
      tick();
      in_valid = 1'b0;
      tick();
      check("t2_data", 64'(data_out), 64'hFF000153);
      tick();

      // Sweep all bytes forward, then invert the forward images
      for (int i = 0; i < 64; i++) begin
         in_valid = 1'b1; op = 2'b01;
         data_in = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
         tick();
      end
      for (int i = 0; i < 64; i++) begin
         in_valid = 1'b1; op = 2'b10;
         data_in = {fwd_tab[4*i+3], fwd_tab[4*i+2], fwd_tab[4*i+1], fwd_tab[4*i]};
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      // 20-transaction stream with out_ready pattern 1,0,0,1
      sent = 0;
      for (int c = 0; c < 200 && sent < 20; c++) begin
         in_valid  = 1'b1;
         op        = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
         data_in   = $urandom();
         out_ready = ((c % 4) == 0) || ((c % 4) == 3);
         tick();
         sent += in_fire;
      end
      check("t3_sent", 64'(sent), 64'd20);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check("t3_drain", 64'(exp_q.size()), 64'd0);

      // Illegal ops: processed as forward, flagged
      in_valid = 1'b1; op = 2'b00; data_in = '0;
      tick();
      op = 2'b11;
      tick();
      check("t4_d00", 64'(data_out), 64'h63636363);
      check("t4_e00", 64'(op_err), 64'd1);
      op = 2'b01;
      tick();
      in_valid = 1'b0;
      check("t4_d11", 64'(data_out), 64'h63636363);
      check("t4_e11", 64'(op_err), 64'd1);
      tick();
      check("t4_d01", 64'(data_out), 64'h63636363);
      check("t4_e01", 64'(op_err), 64'd0);
      tick();

      // Fill pipe under stall, then flush
      out_ready = 1'b0; in_valid = 1'b1; op = 2'b01;
      data_in = $urandom(); tick();
      data_in = $urandom(); tick();
      data_in = $urandom(); tick();
      flush = 1'b1; out_ready = 1'b1; data_in = $urandom();
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("t5_flushed", 64'(out_valid), 64'd0);
      in_valid = 1'b1; op = 2'b10; data_in = 32'hA1B2C3D4;
      tick();
      in_valid = 1'b0;
      check("t5_lat1", 64'(out_valid), 64'd0);
      tick();
      check("t5_lat2", 64'(out_valid), 64'd1);
      check("t5_data", 64'({op_err, data_out}), 64'(expect_word(2'b10, 32'hA1B2C3D4)));
      tick();

      // Random traffic including illegal ops and occasional flush
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         op        = 2'($urandom_range(0, 3));
         data_in   = $urandom();
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         tick();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
      check("rand_drain", 64'(exp_q.size()), 64'd0);

      // Reset mid-stream
      out_ready = 1'b0; in_valid = 1'b1; op = 2'b01;
      data_in = $urandom(); tick();
      data_in = $urandom(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      check("t6_valid", 64'(out_valid), 64'd0);
      check("t6_data", 64'(data_out), 64'd0);
      check("t6_err", 64'(op_err), 64'd0);

      // Single lane, single register: latency 1
      check("b_ready", 64'(b_in_ready), 64'd1);
      check("b_idle", 64'(b_out_valid), 64'd0);
      b_in_valid = 1'b1; b_op = 2'b01; b_data_in = 8'h53;
      tick();
      check("b_fwd_valid", 64'(b_out_valid), 64'd1);
      check("b_fwd_data", 64'(b_data_out), 64'hED);
      check("b_fwd_err", 64'(b_op_err), 64'd0);
      b_op = 2'b10; b_data_in = 8'hED;
      tick();
      check("b_inv_data", 64'(b_data_out), 64'h53);
      b_in_valid = 1'b0;
      tick();
      check("b_drained", 64'(b_out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
